// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_tx_sched_pkg;

   // Transmit FIFO geometry; depth must be a power of two so pointers wrap freely.
   localparam int UARTFifoQueueSize = 32;
   localparam int UARTFifoPtrSize   = $clog2(UARTFifoQueueSize);

   // Core clock cycles per UART bit (CoreFreq / UartBaudRate).
   localparam int UartCmpVal = 173;

   // CSR address that accepts pushes and returns the FIFO status word.
   localparam logic [11:0] UARTFifoCsrAddr = 12'h050;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } UartTxStateT;

   typedef logic [$clog2(UartCmpVal)-1:0] UartBaudCntT;

   // Status word layout: {23'b0, overflow, full, empty, level[5:0]}.
   function automatic logic [31:0] packStatus(input logic overflow, input logic full,
                                              input logic empty, input logic [5:0] level);
      return {23'b0, overflow, full, empty, level};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with sticky overflow flag; head is visible combinationally.
module uart_tx_fifo
   import uart_tx_sched_pkg::*;
#(
   parameter int Depth = UARTFifoQueueSize,
   parameter int Width = 8
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic                    push,
   input  logic [Width-1:0]        pushData,
   input  logic                    pop,
   output logic [Width-1:0]        headData,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow,
   output logic [$clog2(Depth):0]  level
);

   localparam int PtrW   = $clog2(Depth);
   localparam int LevelW = PtrW + 1;

   logic [Width-1:0]  memArr [Depth];
   logic [PtrW-1:0]   wrPtrReg;
   logic [PtrW-1:0]   rdPtrReg;
   logic [LevelW-1:0] levelReg;
   logic              overflowReg;
   logic              pushOk;
   logic              popOk;

   // Fullness is judged before any pop on the same edge, so a push into a
   // full FIFO is dropped even while the head is leaving.
   assign full   = (levelReg == LevelW'(Depth));
   assign empty  = (levelReg == '0);
   assign pushOk = push && !full;
   assign popOk  = pop && !empty;

   // Storage write; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         memArr[wrPtrReg] <= pushData;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         levelReg    <= '0;
         overflowReg <= 1'b0;
      end else begin
         if (pushOk) begin
            wrPtrReg <= wrPtrReg + 1'b1;
         end
         if (popOk) begin
            rdPtrReg <= rdPtrReg + 1'b1;
         end
         if (push && full) begin
            overflowReg <= 1'b1;
         end
         case ({pushOk, popOk})
            2'b10:   levelReg <= levelReg + 1'b1;
            2'b01:   levelReg <= levelReg - 1'b1;
            default: levelReg <= levelReg;
         endcase
      end
   end

   // Head read is combinational so a pop can load the consumer on the same edge.
   assign headData = memArr[rdPtrReg];
   assign level    = levelReg;
   assign overflow = overflowReg;

endmodule

// File: rtl/uart_tx_sched.sv
// CSR-fed UART 8N1 transmitter: push decode, FIFO, bit-timing FSM, drain interrupt.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int          FifoDepth = UARTFifoQueueSize,
   parameter int          CmpVal    = UartCmpVal,
   parameter logic [11:0] CsrAddr   = UARTFifoCsrAddr
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_enable,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        tx,
   output logic        busy,
   output logic        irq_drained
);

   localparam int BaudW = (CmpVal > 1) ? $clog2(CmpVal) : 1;
   typedef logic [BaudW-1:0] BaudCntT;
   localparam BaudCntT BaudLast = BaudCntT'(CmpVal - 1);

   UartTxStateT stateReg, stateNext;
   BaudCntT     baudReg, baudNext;
   logic [2:0]  bitIdxReg, bitIdxNext;
   logic [7:0]  shiftReg, shiftNext;
   logic        txReg, txNext;
   logic        irqReg, irqNext;

   logic                      pushReq;
   logic                      popReq;
   logic                      bitEnd;
   logic [7:0]                fifoHead;
   logic                      fifoFull;
   logic                      fifoEmpty;
   logic                      fifoOverflow;
   logic [$clog2(FifoDepth):0] fifoLevel;
   logic                      unusedWdata;

   // Only the low byte is transmitted; the rest of the write word is ignored.
   assign unusedWdata = ^csr_wdata[31:8];

   assign pushReq = csr_enable && csr_we && (csr_addr == CsrAddr);
   assign bitEnd  = (baudReg == BaudLast);

   uart_tx_fifo #(
      .Depth (FifoDepth),
      .Width (8)
   ) uFifo (
      .clk      (clk),
      .rstN     (reset),
      .push     (pushReq),
      .pushData (csr_wdata[7:0]),
      .pop      (popReq),
      .headData (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .overflow (fifoOverflow),
      .level    (fifoLevel)
   );

   // FSM, baud counter, shift register and registered tx/irq outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg  <= IDLE;
         baudReg   <= '0;
         bitIdxReg <= '0;
         shiftReg  <= '0;
         txReg     <= 1'b1;
         irqReg    <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         baudReg   <= baudNext;
         bitIdxReg <= bitIdxNext;
         shiftReg  <= shiftNext;
         txReg     <= txNext;
         irqReg    <= irqNext;
      end
   end

   // Next-state logic; tx is computed one cycle ahead so the pin is a flop.
   always_comb begin
      stateNext  = stateReg;
      baudNext   = baudReg;
      bitIdxNext = bitIdxReg;
      shiftNext  = shiftReg;
      txNext     = txReg;
      irqNext    = 1'b0;
      popReq     = 1'b0;
      case (stateReg)
         IDLE: begin
            txNext = 1'b1;
            if (!fifoEmpty) begin
               popReq     = 1'b1;
               shiftNext  = fifoHead;
               baudNext   = '0;
               bitIdxNext = '0;
               txNext     = 1'b0;
               stateNext  = START;
            end
         end
         START: begin
            if (bitEnd) begin
               baudNext   = '0;
               bitIdxNext = '0;
               txNext     = shiftReg[0];
               stateNext  = DATA;
            end else begin
               baudNext = baudReg + 1'b1;
            end
         end
         DATA: begin
            if (bitEnd) begin
               baudNext  = '0;
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitIdxReg == 3'd7) begin
                  txNext    = 1'b1;
                  stateNext = STOP;
               end else begin
                  bitIdxNext = bitIdxReg + 3'd1;
                  txNext     = shiftReg[1];
               end
            end else begin
               baudNext = baudReg + 1'b1;
            end
         end
         STOP: begin
            if (bitEnd) begin
               baudNext = '0;
               if (!fifoEmpty) begin
                  // Next byte starts straight after the stop bit, no idle gap.
                  popReq     = 1'b1;
                  shiftNext  = fifoHead;
                  bitIdxNext = '0;
                  txNext     = 1'b0;
                  stateNext  = START;
               end else begin
                  txNext    = 1'b1;
                  irqNext   = 1'b1;
                  stateNext = IDLE;
               end
            end else begin
               baudNext = baudReg + 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
            txNext    = 1'b1;
         end
      endcase
   end

   assign tx          = txReg;
   assign irq_drained = irqReg;
   assign busy        = (stateReg != IDLE);

   // Status reads are side-effect free and decode only the FIFO address.
   assign csr_rdata = (csr_addr == CsrAddr)
                    ? packStatus(fifoOverflow, fifoFull, fifoEmpty, 6'(fifoLevel))
                    : 32'h0;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a frame-level reference model.
module tb_uart_tx_sched;

   localparam int          CMP   = 4;
   localparam int          DEPTH = 32;
   localparam logic [11:0] ADDR  = 12'h050;

   logic        clk;
   logic        reset;
   logic        csr_enable;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        tx;
   logic        busy;
   logic        irq_drained;

   uart_tx_sched #(
      .FifoDepth (DEPTH),
      .CmpVal    (CMP),
      .CsrAddr   (ADDR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .csr_enable  (csr_enable),
      .csr_we      (csr_we),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .tx          (tx),
      .busy        (busy),
      .irq_drained (irq_drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: bytes waiting, bytes handed to the line, frame position.
   logic [7:0] mq[$];
   logic [7:0] sentQ[$];
   logic       mBusy = 1'b0;
   int         mT = 0;
   logic [7:0] mByte = 8'h00;
   logic       mOvf = 1'b0;
   logic       mIrq = 1'b0;

   // Line receiver decoding what actually leaves on tx.
   logic       rxAct = 1'b0;
   int         rxCnt = 0;
   logic [7:0] rxByte = 8'h00;
   int         rxFrames = 0;
   int         irqCount = 0;

   typedef struct {
      logic        en;
      logic        we;
      logic [11:0] addr;
      logic [7:0]  data;
      logic [11:0] rdAddr;
      logic [31:0] expRd;
      logic        expTx;
   } vecT;

   vecT vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Line level of an 8N1 frame t cycles after its start bit began.
   function automatic logic frameBit(input logic [7:0] b, input int t);
      int k;
      k = t / CMP;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic logic [31:0] expStatus(input logic [11:0] addr);
      int sz;
      logic [5:0] lvl;
      sz  = mq.size();
      lvl = 6'(sz);
      if (addr != ADDR) return 32'h0;
      return {23'b0, mOvf, (sz == DEPTH), (sz == 0), lvl};
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic cycle();
      logic doPush;
      logic wasFull;
      int   szPre;
      int   k;
      logic [7:0] expB;
      @(posedge clk);
      doPush = csr_enable && csr_we && (csr_addr == ADDR);
      if (!reset) begin
         mq.delete();
         sentQ.delete();
         mBusy = 1'b0;
         mT    = 0;
         mOvf  = 1'b0;
         mIrq  = 1'b0;
      end else begin
         szPre   = mq.size();
         wasFull = (szPre == DEPTH);
         mIrq    = 1'b0;
         if (mBusy) begin
            if (mT == 10*CMP - 1) begin
               if (szPre > 0) begin
                  mByte = mq.pop_front();
                  sentQ.push_back(mByte);
                  mT = 0;
               end else begin
                  mBusy = 1'b0;
                  mIrq  = 1'b1;
               end
            end else begin
               mT++;
            end
         end else if (szPre > 0) begin
            mByte = mq.pop_front();
            sentQ.push_back(mByte);
            mBusy = 1'b1;
            mT    = 0;
         end
         if (doPush) begin
            if (wasFull) mOvf = 1'b1;
            else mq.push_back(csr_wdata[7:0]);
            $display("push data=%h %s level=%0d", csr_wdata[7:0],
                     wasFull ? "dropped" : "queued", mq.size());
         end
      end
      #1;
      chk("tx", 32'(tx), 32'(mBusy ? frameBit(mByte, mT) : 1'b1));
      chk("busy", 32'(busy), 32'(mBusy));
      chk("irq", 32'(irq_drained), 32'(mIrq));
      chk("rdata", csr_rdata, expStatus(csr_addr));
      if (irq_drained === 1'b1) irqCount++;
      if (!reset) begin
         rxAct = 1'b0;
      end else if (!rxAct) begin
         if (tx === 1'b0) begin
            rxAct = 1'b1;
            rxCnt = 0;
         end
      end else begin
         rxCnt++;
         if (rxCnt % CMP == CMP / 2) begin
            k = rxCnt / CMP;
            if (k == 0) begin
               chk("startBit", 32'(tx), 32'h0);
            end else if (k <= 8) begin
               rxByte[k-1] = tx;
            end else begin
               chk("stopBit", 32'(tx), 32'h1);
               if (sentQ.size() == 0) begin
                  chk("rxExtra", 32'(sentQ.size()), 32'h1);
               end else begin
                  expB = sentQ.pop_front();
                  chk("rxByte", 32'(rxByte), 32'(expB));
               end
               rxFrames++;
               $display("rx frame data=%h", rxByte);
               rxAct = 1'b0;
            end
         end
      end
   endtask

   task automatic idleBus();
      csr_enable = 1'b0;
      csr_we     = 1'b0;
      csr_wdata  = 32'h0;
      csr_addr   = ADDR;
   endtask

   task automatic push(input logic [7:0] d);
      logic [31:0] rnd;
      rnd        = $urandom();
      csr_enable = 1'b1;
      csr_we     = 1'b1;
      csr_addr   = ADDR;
      csr_wdata  = {rnd[31:8], d};
      cycle();
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic doReset();
      reset = 1'b0;
      #1;
      chk("rstTx", 32'(tx), 32'h1);
      chk("rstBusy", 32'(busy), 32'h0);
      chk("rstIrq", 32'(irq_drained), 32'h0);
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((busy || mBusy || mq.size() != 0) && n < bound) begin
         cycle();
         n++;
      end
      chk("drainDone", 32'(busy), 32'h0);
      cycle();
      cycle();
   endtask

   initial begin
      logic [9:0]  pat;
      logic [31:0] rnd;
      int          base;
      int          frames;
      int          n;
      int          r;

      vecs[0] = '{en:1'b1, we:1'b1, addr:12'h051, data:8'hAA, rdAddr:12'h050, expRd:32'h40, expTx:1'b1};
      vecs[1] = '{en:1'b1, we:1'b0, addr:12'h050, data:8'hBB, rdAddr:12'h050, expRd:32'h40, expTx:1'b1};
      vecs[2] = '{en:1'b0, we:1'b1, addr:12'h050, data:8'hCC, rdAddr:12'h050, expRd:32'h40, expTx:1'b1};
      vecs[3] = '{en:1'b1, we:1'b1, addr:12'h050, data:8'h55, rdAddr:12'h050, expRd:32'h01, expTx:1'b1};
      vecs[4] = '{en:1'b0, we:1'b0, addr:12'h050, data:8'h00, rdAddr:12'h051, expRd:32'h00, expTx:1'b0};

      reset = 1'b0;
      idleBus();
      cycle();
      cycle();
      chk("resetTx", 32'(tx), 32'h1);
      chk("resetBusy", 32'(busy), 32'h0);
      chk("resetStatus", csr_rdata, 32'h40);
      reset = 1'b1;
      cycle();

      // CSR decode and first-frame latency.
      for (int i = 0; i < 5; i++) begin
         csr_enable = vecs[i].en;
         csr_we     = vecs[i].we;
         csr_addr   = vecs[i].addr;
         csr_wdata  = {24'hABCDEF, vecs[i].data};
         cycle();
         idleBus();
         csr_addr = vecs[i].rdAddr;
         #1;
         chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].expRd);
         chk($sformatf("vec%0d_tx", i), 32'(tx), 32'(vecs[i].expTx));
         $display("vec %0d en=%b we=%b addr=%h rdata=%h", i, vecs[i].en, vecs[i].we,
                  vecs[i].addr, csr_rdata);
      end
      csr_addr = ADDR;

      // 0x55 frame: alternating line, 4 cycles per bit, single irq at cycle 40.
      pat  = 10'b1010101010;
      base = irqCount;
      for (int c = 1; c < 10*CMP; c++) begin
         cycle();
         chk($sformatf("pat55_c%0d", c), 32'(tx), 32'(pat[c/CMP]));
      end
      cycle();
      chk("irq55", 32'(irq_drained), 32'h1);
      cycle();
      chk("irq55Count", 32'(irqCount - base), 32'h1);

      // Three back-to-back frames with no idle gap and one irq at the end.
      push(8'hA3);
      push(8'h00);
      push(8'hFF);
      idleBus();
      #1;
      chk("b2bLevel", csr_rdata, 32'h02);
      base = irqCount;
      n = 2;
      for (int k = 0; k < 200; k++) begin
         cycle();
         if (busy) n++;
         else break;
      end
      chk("b2bLen", 32'(n), 32'd120);
      chk("b2bIrq", 32'(irq_drained), 32'h1);
      cycle();
      chk("b2bIrqCount", 32'(irqCount - base), 32'h1);

      // 33 pushes while one frame holds the FSM: 33rd dropped, sticky overflow.
      frames = rxFrames;
      push(8'h11);
      idleBus();
      cycle();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
      idleBus();
      #1;
      chk("fullStatus", csr_rdata, 32'h0A0);
      push(8'hEE);
      idleBus();
      #1;
      chk("ovfStatus", csr_rdata, 32'h1A0);
      drain(2000);
      chk("ovfFrames", 32'(rxFrames - frames), 32'd33);
      chk("ovfStillSet", csr_rdata, 32'h140);
      doReset();
      cycle();

      // Push on the very edge that pops from a full FIFO: dropped, level 31.
      push(8'h22);
      idleBus();
      cycle();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
      idleBus();
      repeat (10*CMP - 1 - DEPTH) cycle();
      chk("prePopStatus", csr_rdata, 32'h0A0);
      push(8'hEE);
      idleBus();
      #1;
      chk("popPushStatus", csr_rdata, 32'h11F);
      chk("popPushTx", 32'(tx), 32'h0);
      doReset();
      cycle();

      // Reset in the middle of the second of three queued frames.
      push(8'h3C);
      push(8'h00);
      push(8'h5A);
      idleBus();
      repeat (49) cycle();
      chk("midFrameTx", 32'(tx), 32'h0);
      chk("midFrameBusy", 32'(busy), 32'h1);
      doReset();
      frames = rxFrames;
      repeat (100) cycle();
      chk("postRstStatus", csr_rdata, 32'h40);
      chk("postRstBusy", 32'(busy), 32'h0);
      chk("postRstFrames", 32'(rxFrames - frames), 32'h0);

      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         r   = $urandom_range(0, 99);
         rnd = $urandom();
         if (r < 4) begin
            csr_enable = 1'b1;
            csr_we     = 1'b1;
            csr_addr   = ADDR;
            csr_wdata  = rnd;
         end else if (r < 6) begin
            csr_enable = 1'b1;
            csr_we     = 1'b1;
            csr_addr   = 12'h051;
            csr_wdata  = rnd;
         end else if (r < 9) begin
            csr_enable = 1'b1;
            csr_we     = 1'b0;
            csr_addr   = ADDR;
            csr_wdata  = rnd;
         end else begin
            csr_enable = 1'b0;
            csr_we     = rnd[0];
            csr_addr   = rnd[1] ? ADDR : 12'h3FF;
            csr_wdata  = rnd;
         end
         cycle();
      end
      idleBus();
      drain(3000);
      chk("sentLeft", 32'(sentQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
